// File: rtl/counter_seek_arbiter.sv
// Round-robin arbiter that shares one saturating up/down/load counter
// between two requesters. Each granted request drives the counter to
// a target value, either one step per cycle (seek) or by a direct load.
// It reports completion per requester, with err set when the request
// failed.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; arbitrates and latches the owner
// CHECK | one cycle to validate the target and pick LOAD/SEEK/RESP
// SEEK  | step the counter toward the target, bounded by the timer
// LOAD  | one cycle of load strobe with the target on data
// RESP  | done pulse for the owner; pointer passes to the other side
module counter_seek_arbiter #(
    parameter int MAX_VAL    = 12,
    parameter int ERR_VAL    = 15,
    parameter int SEEK_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [5:0] tgt0,
    input  logic       mode0,
    input  logic       req1,
    input  logic [5:0] tgt1,
    input  logic       mode1,
    input  logic [3:0] cnt_out,
    output logic       en,
    output logic       dir,
    output logic       load,
    output logic [5:0] data,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SEEK  = 3'd2,
        LOAD  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [5:0] tgt_q,   tgt_d;
    logic       mode_q,  mode_d;
    logic       ptr_q,   ptr_d;
    logic [3:0] timer_q, timer_d;
    logic       err_q,   err_d;
    logic [1:0] gnt_q,   gnt_d;

    logic       pick;
    logic [5:0] cnt_ext;
    logic       cnt_is_err;
    logic       at_target;

    // The target is 6 bits wide, so compare against a zero-extended count.
    assign cnt_ext    = {2'b00, cnt_out};
    assign cnt_is_err = (cnt_out == 4'(ERR_VAL));
    assign at_target  = (cnt_ext == tgt_q);

    // State, latched request and arbitration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            tgt_q   <= '0;
            mode_q  <= 1'b0;
            ptr_q   <= 1'b0;
            timer_q <= '0;
            err_q   <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            tgt_q   <= tgt_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state logic and the counter control decode.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        tgt_d   = tgt_q;
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        err_d   = err_q;
        gnt_d   = '0;
        en      = 1'b0;
        dir     = 1'b0;
        load    = 1'b0;
        data    = '0;
        // A lone requester wins; on a tie the pointer decides.
        pick    = (req0 && req1) ? ptr_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d     = pick;
                    tgt_d       = pick ? tgt1 : tgt0;
                    mode_d      = pick ? mode1 : mode0;
                    err_d       = 1'b0;
                    gnt_d[pick] = 1'b1;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if ((tgt_q > 6'(MAX_VAL)) || cnt_is_err) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (mode_q) begin
                    state_d = LOAD;
                end else if (at_target) begin
                    state_d = RESP;
                end else begin
                    timer_d = '0;
                    state_d = SEEK;
                end
            end
            SEEK: begin
                if (cnt_is_err) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (at_target) begin
                    state_d = RESP;
                end else if (timer_q == 4'(SEEK_LIMIT)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    en      = 1'b1;
                    dir     = (tgt_q > cnt_ext);
                    timer_d = timer_q + 4'd1;
                end
            end
            LOAD: begin
                en      = 1'b1;
                load    = 1'b1;
                data    = tgt_q;
                state_d = RESP;
            end
            RESP: begin
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt0  = gnt_q[0];
    assign gnt1  = gnt_q[1];
    assign done0 = (state_q == RESP) && !owner_q;
    assign done1 = (state_q == RESP) && owner_q;
    assign err   = (state_q == RESP) && err_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_counter_seek_arbiter.sv
// Bench for counter_seek_arbiter: a stub counter (with preset and freeze
// hooks) sits behind the arbiter. Directed requests push hand-computed
// completions into a scoreboard that a separate monitor checks on done.
module tb_counter_seek_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, mode0, req1, mode1;
    logic [5:0] tgt0, tgt1;
    logic [3:0] cnt_model;
    logic       en, dir, load;
    logic [5:0] data;
    logic       gnt0, gnt1, done0, done1, err, busy;

    logic       preset_en = 1'b0;
    logic [3:0] preset_val = 4'd0;
    logic       freeze = 1'b0;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int owner;
        int err;
        int cnt;
        int lat;
    } exp_t;

    exp_t sb[$];

    counter_seek_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .tgt0    (tgt0),
        .mode0   (mode0),
        .req1    (req1),
        .tgt1    (tgt1),
        .mode1   (mode1),
        .cnt_out (cnt_model),
        .en      (en),
        .dir     (dir),
        .load    (load),
        .data    (data),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .err     (err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub counter: saturating 0..12, 15 is sticky, plus bench overrides.
    always @(posedge clk or posedge rst) begin
        if (rst)
            cnt_model <= 4'd0;
        else if (preset_en)
            cnt_model <= preset_val;
        else if (freeze || cnt_model == 4'd15)
            cnt_model <= cnt_model;
        else if (en) begin
            if (load)
                cnt_model <= (data > 6'd12) ? 4'd15 : data[3:0];
            else if (dir)
                cnt_model <= (cnt_model == 4'd12) ? 4'd12 : cnt_model + 4'd1;
            else
                cnt_model <= (cnt_model == 4'd0) ? 4'd0 : cnt_model - 4'd1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic expect_done(input int o, input int e, input int c, input int l);
        exp_t x;
        x.owner = o;
        x.err   = e;
        x.cnt   = c;
        x.lat   = l;
        sb.push_back(x);
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        int   gcyc;
        exp_t e;
        gcyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gcyc = cyc;
            end else begin
                if (gnt0 || gnt1) gcyc = cyc;
                if (done0 || done1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", int'(done1), -1);
                    end else begin
                        e = sb.pop_front();
                        chk("done_owner", int'(done1), e.owner);
                        chk("done_err", int'(err), e.err);
                        chk("done_cnt", int'(cnt_model), e.cnt);
                        chk("done_latency", cyc - gcyc, e.lat);
                    end
                end
            end
        end
    end

    task automatic preset(input logic [3:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Issue one or two requests, drop each on its grant, wait for all dones.
    task automatic serve(input logic r0, input logic [5:0] t0, input logic m0,
                         input logic r1, input logic [5:0] t1, input logic m1,
                         output int en_n, output int up_n, output int load_n,
                         output int last_data, output int gnt_lat);
        int need;
        int seen;
        need      = int'(r0) + int'(r1);
        seen      = 0;
        en_n      = 0;
        up_n      = 0;
        load_n    = 0;
        last_data = -1;
        gnt_lat   = -1;
        tgt0 = t0; mode0 = m0; req0 = r0;
        tgt1 = t1; mode1 = m1; req1 = r1;
        for (int i = 0; i < 80 && seen < need; i++) begin
            @(negedge clk);
            if ((gnt0 || gnt1) && gnt_lat < 0) gnt_lat = i + 1;
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            if (en) en_n++;
            if (en && dir) up_n++;
            if (load) begin
                load_n++;
                last_data = int'(data);
            end
            if (done0 || done1) seen++;
        end
        chk("requests_served", seen, need);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int en_n, up_n, load_n, last_data, gnt_lat;
        int steps;
        rst = 1'b1;
        req0 = 1'b0; tgt0 = '0; mode0 = 1'b0;
        req1 = 1'b0; tgt1 = '0; mode1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("outputs_in_reset", int'({en, dir, load, data, gnt0, gnt1, done0, done1, err, busy}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("outputs_after_reset", int'({en, dir, load, data, gnt0, gnt1, done0, done1, err, busy}), 0);

        // Seek 0 -> 5.
        expect_done(0, 0, 5, 7);
        serve(1, 6'd5, 0, 0, 6'd0, 0, en_n, up_n, load_n, last_data, gnt_lat);
        chk("seek5_gnt_latency", gnt_lat, 1);
        chk("seek5_en_cycles", en_n, 5);
        chk("seek5_up_cycles", up_n, 5);

        // Direct load 9 -> 3.
        preset(4'd9);
        expect_done(1, 0, 3, 2);
        serve(0, 6'd0, 0, 1, 6'd3, 1, en_n, up_n, load_n, last_data, gnt_lat);
        chk("load3_strobes", load_n, 1);
        chk("load3_data", last_data, 3);

        // Tie with pointer on 0: seek 3 -> 2, then requester 1 already there.
        expect_done(0, 0, 2, 3);
        expect_done(1, 0, 2, 1);
        serve(1, 6'd2, 0, 1, 6'd2, 0, en_n, up_n, load_n, last_data, gnt_lat);
        chk("tie_a_en_cycles", en_n, 1);
        chk("tie_a_up_cycles", up_n, 0);

        // Lone requester 0 moves the pointer to 1.
        expect_done(0, 0, 2, 2);
        serve(1, 6'd2, 1, 0, 6'd0, 0, en_n, up_n, load_n, last_data, gnt_lat);

        // Tie again: requester 1 seeks 2 -> 7 first, then 0 loads 4.
        expect_done(1, 0, 7, 7);
        expect_done(0, 0, 4, 2);
        serve(1, 6'd4, 1, 1, 6'd7, 0, en_n, up_n, load_n, last_data, gnt_lat);
        chk("tie_b_up_cycles", up_n, 5);
        chk("tie_b_load_data", last_data, 4);

        // Out-of-range target: rejected in CHECK, counter untouched.
        expect_done(0, 1, 4, 1);
        serve(1, 6'd13, 0, 0, 6'd0, 0, en_n, up_n, load_n, last_data, gnt_lat);
        chk("range_en_cycles", en_n, 0);
        chk("range_load_cycles", load_n, 0);

        // Counter stuck at error code.
        preset(4'd15);
        expect_done(1, 1, 15, 1);
        serve(0, 6'd0, 0, 1, 6'd4, 0, en_n, up_n, load_n, last_data, gnt_lat);
        chk("errcnt_en_cycles", en_n, 0);
        pulse_rst();
        chk("cnt_after_rst", int'(cnt_model), 0);

        // Frozen counter: timer expires after 15 stepping cycles.
        freeze = 1'b1;
        expect_done(0, 1, 0, 17);
        serve(1, 6'd8, 0, 0, 6'd0, 0, en_n, up_n, load_n, last_data, gnt_lat);
        chk("timeout_en_cycles", en_n, 15);
        freeze = 1'b0;

        // Reset mid-seek at count 3 of target 10: no done for that request.
        tgt0 = 6'd10; mode0 = 1'b0; req0 = 1'b1;
        steps = 0;
        while (cnt_model != 4'd3 && steps < 40) begin
            @(negedge clk);
            if (gnt0) req0 = 1'b0;
            steps++;
        end
        chk("reached_3_mid_seek", int'(cnt_model), 3);
        rst = 1'b1;
        #1;
        chk("outputs_on_abort", int'({en, dir, load, data, gnt0, gnt1, done0, done1, err, busy}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_abort", int'({busy, done0, done1}), 0);
        expect_done(1, 0, 1, 2);
        serve(0, 6'd0, 0, 1, 6'd1, 1, en_n, up_n, load_n, last_data, gnt_lat);
        chk("fresh_gnt_latency", gnt_lat, 1);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
